// File: rtl/crc16_pkg.sv
// Shared constants, FSM state type and the single-step CRC-16 LFSR update
// used by the bit-serial CRC scheduler.
package crc16_pkg;

    localparam int CRC_W  = 16;
    localparam int DATA_W = 32;
    localparam logic [CRC_W-1:0] POLY = 16'h1021;
    localparam logic [CRC_W-1:0] INIT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One MSB-first LFSR step: feedback is the incoming bit xor the CRC MSB.
    function automatic logic [CRC_W-1:0] crc16_step(
        input logic [CRC_W-1:0] crc,
        input logic             din,
        input logic [CRC_W-1:0] poly
    );
        logic fb;
        fb = din ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : {CRC_W{1'b0}});
    endfunction

endpackage

// File: rtl/crc16_rr_arb.sv
// Round-robin arbiter: picks the first valid requester at or after the rr
// pointer (wrapping) and moves the pointer past the winner on accept.
module crc16_rr_arb #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_i,
    input  logic             accept_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] rr_d;
    logic             found;
    int               pos;

    assign any_o = |req_i;

    always_comb begin
        idx_o   = '0;
        grant_o = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(rr_q) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!found && req_i[pos]) begin
                found = 1'b1;
                idx_o = IDX_W'(pos);
            end
        end
        if (found) begin
            grant_o[idx_o] = 1'b1;
        end
    end

    // Pointer values stay below NREQ, so a non-power-of-two NREQ wraps correctly.
    always_comb begin
        rr_d = rr_q;
        if (accept_i) begin
            rr_d = (idx_o == IDX_W'(NREQ - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/crc16_serial_sched.sv
// Shares one bit-serial CRC-16/CCITT engine among NREQ valid/ready requesters
// using a round-robin grant; results return with the owning requester index.
module crc16_serial_sched #(
    parameter  int                 NREQ   = 4,
    parameter  int                 DATA_W = crc16_pkg::DATA_W,
    parameter  int                 CRC_W  = crc16_pkg::CRC_W,
    parameter  logic [CRC_W-1:0]   POLY   = crc16_pkg::POLY,
    parameter  logic [CRC_W-1:0]   INIT   = crc16_pkg::INIT,
    localparam int                 IDX_W  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*DATA_W-1:0] req_data_i,
    output logic [NREQ-1:0]        req_ready_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [CRC_W-1:0]       res_crc_o,
    output logic [IDX_W-1:0]       res_id_o,
    output logic                   busy_o
);

    import crc16_pkg::*;

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   shreg_q;
    logic [CRC_W-1:0]    crc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    id_q;

    logic [NREQ-1:0]     grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                any_valid;
    logic                accept;
    logic [DATA_W-1:0]   data_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data_i[gi*DATA_W +: DATA_W];
    end

    crc16_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_valid_i),
        .accept_i (accept),
        .grant_o  (grant),
        .idx_o    (grant_idx),
        .any_o    (any_valid)
    );

    // Grants are gated by rst so every output reads 0 while reset is held.
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        accept      = 1'b0;
        res_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid && !rst) begin
                    req_ready_o = grant;
                    accept      = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                busy_o = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_o      = 1'b1;
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            crc_q   <= INIT;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_q <= data_arr[grant_idx];
                        crc_q   <= INIT;
                        cnt_q   <= '0;
                        id_q    <= grant_idx;
                    end
                end
                SHIFT: begin
                    crc_q   <= crc16_step(crc_q, shreg_q[DATA_W-1], POLY);
                    shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
                    cnt_q   <= cnt_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign res_crc_o = crc_q;
    assign res_id_o  = id_q;

endmodule

// File: tb/tb_crc16_serial_sched.sv
// Scoreboard bench: per-requester expected CRC queues are filled when words
// are offered; a monitor pops and compares on every result handshake.
module tb_crc16_serial_sched;

    localparam int NREQ   = 4;
    localparam int DATA_W = 32;

    typedef struct {
        logic [31:0] d;
        logic [15:0] e;
    } job_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   res_valid;
    logic                   res_ready = 1'b1;
    logic [15:0]            res_crc;
    logic [1:0]             res_id;
    logic                   busy;

    int   asserts = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   last_grant_cyc = 0;
    int   pushed  = 0;
    int   results = 0;
    job_t word_q [NREQ][$];
    logic [15:0] exp_q [NREQ][$];
    int   grants [$];
    bit   pend_acc [NREQ];

    crc16_serial_sched #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_crc_o   (res_crc),
        .res_id_o    (res_id),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-at-a-time formulation of the non-augmented CRC-16/CCITT, seed 0.
    function automatic logic [15:0] ref_crc(input logic [31:0] w);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'h0000;
        for (int n = 3; n >= 0; n--) begin
            b = w[n*8 +: 8];
            c = c ^ {b, 8'h00};
            for (int k = 0; k < 8; k++) begin
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic offer(input int id, input logic [31:0] d, input logic [15:0] e);
        job_t j;
        j.d = d;
        j.e = e;
        word_q[id].push_back(j);
        pushed++;
    endtask

    function automatic bit pending();
        bit p;
        p = busy || res_valid || (req_valid != '0);
        for (int i = 0; i < NREQ; i++) begin
            if (word_q[i].size() != 0 || exp_q[i].size() != 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (pending() && n < 4000) begin
            @(negedge clk);
            #4;
            n++;
        end
        if (n >= 4000) chk({name, "_drain_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_res_valid(input string name);
        int n;
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 200) chk({name, "_res_valid_timeout"}, 32'd0, 32'd1);
    endtask

    // Requester driver: one word per requester in flight; drops valid after accept.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (pend_acc[i]) begin
                req_valid[i] = 1'b0;
                pend_acc[i]  = 1'b0;
            end
            if (!req_valid[i] && word_q[i].size() != 0) begin
                job_t j;
                j = word_q[i].pop_front();
                req_data[i*DATA_W +: DATA_W] = j.d;
                req_valid[i] = 1'b1;
                exp_q[i].push_back(j.e);
            end
        end
        #1;
        if (req_ready != '0) begin
            chk("grant_onehot", 32'($onehot(req_ready)), 32'd1);
            chk("grant_while_busy", 32'(busy), 32'd0);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    chk("grant_to_valid", 32'(req_valid[i]), 32'd1);
                    pend_acc[i] = 1'b1;
                    grants.push_back(i);
                    last_grant_cyc = cyc;
                end
            end
        end
    end

    // Result monitor.
    initial forever begin
        @(negedge clk);
        #3;
        if (!rst && res_valid && res_ready) begin
            int id;
            id = int'(res_id);
            results++;
            if (exp_q[id].size() == 0) begin
                chk("unexpected_result", {16'h0, res_crc}, 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = exp_q[id].pop_front();
                chk($sformatf("res_crc_id%0d", id), 32'(res_crc), 32'(e));
                $display("result id=%0d crc=%h expected=%h", id, res_crc, e);
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        int hs_cyc;
        int n;
        logic [31:0] w;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_crc", 32'(res_crc), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single job, latency 33 from accept
        offer(0, 32'h0000_0001, 16'h1021);
        wait_res_valid("t1");
        chk("t1_latency", 32'(cyc - last_grant_cyc), 32'd33);
        chk("t1_res_id", 32'(res_id), 32'd0);
        drain("t1");

        // Linearity on requester 3 (leaves rr pointer at 0)
        offer(3, 32'h0000_0002, 16'h2042);
        offer(3, 32'h0000_0003, 16'h3063);
        offer(3, 32'h0000_0000, 16'h0000);
        drain("t2");

        // All four at once: grant order 0,1,2,3
        grants.delete();
        offer(0, 32'h0000_0001, 16'h1021);
        offer(1, 32'h0000_0002, 16'h2042);
        offer(2, 32'h0000_0004, 16'h4084);
        offer(3, 32'h0000_0008, 16'h8108);
        drain("t3a");
        chk("t3a_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            chk($sformatf("t3a_grant%0d", i), 32'(grants[i]), 32'(i));
        end

        // Requesters 0 and 2 continuously valid: alternate 0,2,0,2
        grants.delete();
        offer(0, 32'h0000_0010, 16'h1231);
        offer(0, 32'h0000_0018, 16'h9339);
        offer(2, 32'h0000_0080, 16'h9188);
        offer(2, 32'h0000_0100, 16'h3331);
        drain("t3b");
        chk("t3b_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            chk($sformatf("t3b_grant%0d", i), 32'(grants[i]), (i % 2 == 0) ? 32'd0 : 32'd2);
        end

        // Backpressure: 10 stalled cycles in DONE with another requester waiting
        @(negedge clk);
        res_ready = 1'b0;
        offer(1, 32'h0000_0003, 16'h3063);
        wait_res_valid("t4");
        offer(2, 32'h0000_0002, 16'h2042);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            chk("t4_res_valid", 32'(res_valid), 32'd1);
            chk("t4_res_crc", 32'(res_crc), 32'h3063);
            chk("t4_res_id", 32'(res_id), 32'd1);
            chk("t4_req_ready", 32'(req_ready), 32'd0);
            chk("t4_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        res_ready = 1'b1;
        hs_cyc = cyc;
        drain("t4");
        chk("t4_grant_after_release", 32'(last_grant_cyc - hs_cyc), 32'd1);

        // Reset in the middle of SHIFT drops the job silently
        offer(0, 32'hFFFF_FFFF, 16'h0000);
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("t5_job_started", 32'(busy), 32'd1);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
        chk("t5_rst_res_valid", 32'(res_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_res_crc", 32'(res_crc), 32'd0);
        chk("t5_rst_res_id", 32'(res_id), 32'd0);
        exp_q[0].delete();
        pushed--;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        offer(1, 32'h0000_0001, 16'h1021);
        drain("t5");

        // Random jobs with random result backpressure against the reference model
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            res_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                int id;
                id = int'($urandom_range(0, NREQ - 1));
                w  = $urandom;
                offer(id, w, ref_crc(w));
                n++;
            end
        end
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            res_ready = 1'($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        drain("t6");
        chk("t6_results_vs_jobs", 32'(results), 32'(pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
